// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and frame check for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } ps2_state_e;

  // Frame layout after the start bit: [7:0] data, [8] parity, [9] stop.
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (^f[8:0]) && f[9];
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronisers for PS/2 clock/data plus a FILTER_LEN-cycle glitch
// filter on the clock; emits a one-cycle strobe on each filtered falling edge.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk,
  input  logic ps2data,
  output logic fall,
  output logic data
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt      <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2clk};
      data_sync <= {data_sync[0], ps2data};
      fall      <= 1'b0;
      // Any sample matching the current filtered level restarts the run.
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data = data_sync[1];

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes device-to-host bytes into a small FIFO.
// Define PS2_BREAK_DECODE_EN to fold E0/F0 prefixes into o_ext/o_brk flags.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] o_data,
  output logic       o_ext,
  output logic       o_brk,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_err,
  output logic       o_ovf
);

  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
`ifdef PS2_BREAK_DECODE_EN
  localparam int unsigned EW = 10;
`else
  localparam int unsigned EW = 8;
`endif

  logic                      fall;
  logic                      data;
  ps2_state_e                state, state_nxt;
  logic [PS2_FRAME_BITS-1:0] shreg;
  logic [3:0]                bitcnt;
  logic [TW-1:0]             tcnt;
  logic                      timeout;
  logic                      frame_good;
  logic                      frame_bad;
  logic                      timeout_err;
  logic                      push;
  logic [EW-1:0]             push_entry;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk    (clk),
    .reset  (reset),
    .ps2clk (ps2clk),
    .ps2data(ps2data),
    .fall   (fall),
    .data   (data)
  );

  assign timeout     = !fall && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_err = (state == SHIFT) && timeout;
  assign frame_good  = (state == CHECK) && frame_ok(shreg);
  assign frame_bad   = (state == CHECK) && !frame_ok(shreg);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall && !data) state_nxt = SHIFT;
      SHIFT: begin
        if (timeout) state_nxt = IDLE;
        else if (fall && bitcnt == 4'(PS2_FRAME_BITS - 1)) state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
      tcnt   <= '0;
    end else if (state == SHIFT) begin
      if (fall) begin
        shreg  <= {data, shreg[PS2_FRAME_BITS-1:1]};
        bitcnt <= bitcnt + 1'b1;
        tcnt   <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end else begin
      bitcnt <= '0;
      tcnt   <= '0;
    end
  end

`ifdef PS2_BREAK_DECODE_EN
  logic ext_q, brk_q;
  logic is_prefix;

  assign is_prefix  = (shreg[7:0] == PS2_PREFIX_EXT) || (shreg[7:0] == PS2_PREFIX_BRK);
  assign push       = frame_good && !is_prefix;
  assign push_entry = {ext_q, brk_q, shreg[7:0]};

  // Flags clear on the consuming byte even if the FIFO drops it.
  always_ff @(posedge clk) begin
    if (reset || frame_bad || timeout_err) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (frame_good) begin
      if (shreg[7:0] == PS2_PREFIX_EXT) begin
        ext_q <= 1'b1;
      end else if (shreg[7:0] == PS2_PREFIX_BRK) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end
`else
  assign push       = frame_good;
  assign push_entry = shreg[7:0];
`endif

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, pop, wr;
  logic [EW-1:0] head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && i_ready;
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      o_err <= 1'b0;
      o_ovf <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      o_err <= frame_bad || timeout_err;
      o_ovf <= push && full && !pop;
    end
  end

  assign head    = empty ? '0 : mem[rptr[AW-1:0]];
  assign o_valid = !empty;
  assign o_data  = head[7:0];
`ifdef PS2_BREAK_DECODE_EN
  assign o_ext   = head[9];
  assign o_brk   = head[8];
`else
  assign o_ext   = 1'b0;
  assign o_brk   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: frame vector table plus hand-written
// sequences, with a scoreboard queue checked as the consumer pops entries.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int unsigned HALF = 40;  // PS/2 half-period in system clocks

  logic       clk = 1'b0;
  logic       reset, ps2clk, ps2data, i_ready;
  logic [7:0] o_data;
  logic       o_ext, o_brk, o_valid, o_err, o_ovf;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .CLK_HZ    (1000000),
    .FILTER_LEN(8),
    .TIMEOUT_US(200),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ps2clk (ps2clk),
    .ps2data(ps2data),
    .o_data (o_data),
    .o_ext  (o_ext),
    .o_brk  (o_brk),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_err  (o_err),
    .o_ovf  (o_ovf)
  );

  int         total = 0;
  int         bad   = 0;
  int         err_cnt = 0;
  int         ovf_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_head;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    bit         bad_stop;
    int         exp_err;
    bit         exp_push;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of what a good received byte should produce.
  task automatic expect_byte(input logic [7:0] d);
`ifdef PS2_BREAK_DECODE_EN
    if (d == 8'hE0) m_ext = 1'b1;
    else if (d == 8'hF0) m_brk = 1'b1;
    else begin
      exp_q.push_back({m_ext, m_brk, d});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
`else
    exp_q.push_back({2'b00, d});
`endif
  endtask

  task automatic model_clear();
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int unsigned nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      ps2data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (o_err) err_cnt++;
      if (o_ovf) ovf_cnt++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_entry: got %0h expected none", {o_ext, o_brk, o_data});
        end else begin
          exp_head = exp_q.pop_front();
          chk("entry", {22'd0, o_ext, o_brk, o_data}, {22'd0, exp_head});
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   e0, o0;

    vecs[0] = '{8'h1C, 1'b0, 1'b0, 0, 1'b1};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 1, 1'b0};
    vecs[2] = '{8'h32, 1'b0, 1'b0, 0, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 1'b1, 1, 1'b0};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 0, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 0, 1'b1};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 0, 1'b1};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 1, 1'b0};

    reset = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; i_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {o_valid, o_data, o_ext, o_brk, o_err, o_ovf}, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    // Good frame held in the FIFO, then popped.
    #1 i_ready = 1'b0;
    e0 = err_cnt;
    expect_byte(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("hold_valid", o_valid, 1);
    chk("hold_data", o_data, 8'h1C);
    chk("hold_err", err_cnt - e0, 0);
    @(posedge clk); #1 i_ready = 1'b1;
    @(posedge clk); #1;
    chk("pop_valid_low", o_valid, 0);
    chk("pop_queue", exp_q.size(), 0);

    for (int i = 0; i < 8; i++) begin
      e0 = err_cnt;
      if (vecs[i].exp_push) expect_byte(vecs[i].d);
      if (vecs[i].exp_err != 0) model_clear();
      send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop, 11);
      repeat (30) @(posedge clk);
      chk("vec_err", err_cnt - e0, vecs[i].exp_err);
    end
    wait_drain("vec_drain");
    chk("vec_idle_valid", o_valid, 0);

    // Inter-bit timeout, then recovery.
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 5);
    repeat (300) @(posedge clk);
    chk("timeout_err", err_cnt - e0, 1);
    model_clear();
    e0 = err_cnt;
    expect_byte(8'h32);
    send_frame(8'h32, 1'b0, 1'b0, 11);
    wait_drain("after_timeout_drain");
    chk("after_timeout_err", err_cnt - e0, 0);

    // Prefix sequence.
    e0 = err_cnt;
    expect_byte(8'hE0);
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    expect_byte(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    expect_byte(8'h75);
    send_frame(8'h75, 1'b0, 1'b0, 11);
    wait_drain("prefix_drain");
    chk("prefix_err", err_cnt - e0, 0);

    // Overflow: five frames into a four-deep FIFO with no consumer.
    @(posedge clk); #1 i_ready = 1'b0;
    e0 = err_cnt; o0 = ovf_cnt;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) expect_byte(8'(k));
      send_frame(8'(k), 1'b0, 1'b0, 11);
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("ovf_pulses", ovf_cnt - o0, 1);
    chk("ovf_err", err_cnt - e0, 0);
    chk("ovf_valid", o_valid, 1);
    chk("ovf_head", o_data, 8'h01);
    @(posedge clk); #1 i_ready = 1'b1;
    wait_drain("ovf_drain");
    repeat (2) @(posedge clk); #1;
    chk("ovf_empty", o_valid, 0);

    // Short glitch while idle.
    e0 = err_cnt;
    @(posedge clk); ps2clk = 1'b0;
    repeat (3) @(posedge clk); ps2clk = 1'b1;
    repeat (40) @(posedge clk);
    chk("glitch_err", err_cnt - e0, 0);
    chk("glitch_valid", o_valid, 0);

    // Reset mid-frame, then a clean frame.
    send_frame(8'h55, 1'b0, 1'b0, 4);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midreset_outputs", {o_valid, o_err, o_ovf}, 0);
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    e0 = err_cnt;
    expect_byte(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    wait_drain("midreset_drain");
    repeat (300) @(posedge clk);
    chk("midreset_err", err_cnt - e0, 0);
    chk("midreset_valid", o_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
